// File: rtl/lcd_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pll_ctrl
// Brief    : rPLL sequencing/reconfiguration controller for the LCD pixel
//            clock. Drives PLL RESET and divider selects, supervises lock,
//            retries on timeout and releases the pixel domain once lock has
//            been stable. Accepts runtime divider changes via req/ack.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_pll_ctrl #(
    parameter int         PLL_RST_CYCLES = 16,
    parameter int         LOCK_WAIT      = 2500,
    parameter int         LOCK_TIMEOUT   = 25000,
    parameter int         MAX_RETRY      = 3,
    parameter logic [5:0] INIT_IDSEL     = 6'd0,
    parameter logic [5:0] INIT_FBDSEL    = 6'd0,
    parameter logic [5:0] INIT_ODSEL     = 6'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       lcd_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam logic [2:0] c_ST_RESET_PLL = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAULT     = 3'd4;

    // One shared cycle counter, sized for the longest phase
    localparam int c_CNT_MAX = (PLL_RST_CYCLES > LOCK_WAIT)
                             ? ((PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT)
                             : ((LOCK_WAIT > LOCK_TIMEOUT) ? LOCK_WAIT : LOCK_TIMEOUT);
    localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(LOCK_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]         c_MAX_RETRY = 4'(MAX_RETRY);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_retry;
    logic [3:0]         w_retry_nxt;
    logic               w_accept;
    logic               r_lock_meta;
    logic               r_lock_s;

    logic               w_pll_reset_nxt;
    logic               w_lcd_reset_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;

    logic               r_cfg_ack;
    logic               r_pll_reset;
    logic               r_lcd_reset;
    logic               r_ready;
    logic               r_fault;
    logic [5:0]         r_idsel;
    logic [5:0]         r_fbdsel;
    logic [5:0]         r_odsel;

    // State, counters, lock synchroniser and latched divider selects
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_idsel     <= INIT_IDSEL;
            r_fbdsel    <= INIT_FBDSEL;
            r_odsel     <= INIT_ODSEL;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            // Selects only move on the edge that also raises pll_reset
            if (w_accept) begin
                r_idsel  <= cfg_idsel;
                r_fbdsel <= cfg_fbdsel;
                r_odsel  <= cfg_odsel;
            end
        end
    end

    // Next-state, counter and retry logic; an accepted request overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_retry_nxt = r_retry;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_RESET_PLL: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = c_ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry < c_MAX_RETRY) begin
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = c_ST_RESET_PLL;
                    end else begin
                        w_state_nxt = c_ST_FAULT;
                    end
                end
            end
            c_ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_WAIT_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            c_ST_RUN: begin
                w_cnt_nxt = '0;
                if (cfg_req) begin
                    w_accept = 1'b1;
                end else if (!r_lock_s) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end
            end
            c_ST_FAULT: begin
                w_cnt_nxt = '0;
                if (cfg_req) begin
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_accept) begin
            w_state_nxt = c_ST_RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end
    end

    // Output decode from the upcoming state so registered outputs track r_state
    always_comb begin
        w_pll_reset_nxt = (w_state_nxt == c_ST_RESET_PLL) || (w_state_nxt == c_ST_FAULT);
        w_lcd_reset_nxt = (w_state_nxt != c_ST_RUN);
        w_ready_nxt     = (w_state_nxt == c_ST_RUN);
        w_fault_nxt     = (w_state_nxt == c_ST_FAULT);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_ack   <= 1'b0;
            r_pll_reset <= 1'b1;
            r_lcd_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_cfg_ack   <= w_accept;
            r_pll_reset <= w_pll_reset_nxt;
            r_lcd_reset <= w_lcd_reset_nxt;
            r_ready     <= w_ready_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign cfg_ack    = r_cfg_ack;
    assign pll_reset  = r_pll_reset;
    assign lcd_reset  = r_lcd_reset;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign retry_cnt  = r_retry;
    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;

endmodule
`default_nettype wire

// File: tb/tb_lcd_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_pll_ctrl
// Brief    : Self-checking bench for lcd_pll_ctrl: vector table for the
//            start-up and timeout sequences, hand sequences for handshake,
//            lock loss, fault recovery and mid-sequence reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_pll_ctrl;

    localparam logic [5:0]  c_INIT_ID  = 6'd1;
    localparam logic [5:0]  c_INIT_FB  = 6'd2;
    localparam logic [5:0]  c_INIT_OD  = 6'd4;
    localparam logic [17:0] c_INIT_SEL = {c_INIT_ID, c_INIT_FB, c_INIT_OD};

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_req;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       cfg_ack;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       lcd_reset, ready, fault;
    logic [3:0] retry_cnt;

    lcd_pll_ctrl #(
        .PLL_RST_CYCLES(4),
        .LOCK_WAIT     (8),
        .LOCK_TIMEOUT  (32),
        .MAX_RETRY     (2),
        .INIT_IDSEL    (c_INIT_ID),
        .INIT_FBDSEL   (c_INIT_FB),
        .INIT_ODSEL    (c_INIT_OD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_req   (cfg_req),
        .cfg_idsel (cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel (cfg_odsel),
        .cfg_ack   (cfg_ack),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .lcd_reset (lcd_reset),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         restart;
        bit         lock;
        int         cyc;
        logic       pr;
        logic       lr;
        logic       rdy;
        logic       flt;
        logic       ack;
        logic [3:0] retry;
    } vec_t;

    vec_t vecs[18];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle    = 0;
    int   acks     = 0;
    int   pr_rises = 0;
    int   lcd_low  = 0;
    logic prev_pr  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic pr, input logic lr, input logic rdy,
                            input logic flt, input logic ack, input logic [3:0] retry);
        chk({tag, ".pll_reset"}, 32'(pll_reset), 32'(pr));
        chk({tag, ".lcd_reset"}, 32'(lcd_reset), 32'(lr));
        chk({tag, ".ready"},     32'(ready),     32'(rdy));
        chk({tag, ".fault"},     32'(fault),     32'(flt));
        chk({tag, ".cfg_ack"},   32'(cfg_ack),   32'(ack));
        chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(retry));
    endtask

    task automatic chk_sel(input string tag, input logic [17:0] exp);
        chk({tag, ".sel"}, 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(exp));
    endtask

    // Advance one cycle; sample on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cycle++;
        if (cfg_ack) acks++;
        if (pll_reset && !prev_pr) pr_rises++;
        if (!lcd_reset) lcd_low++;
        prev_pr = pll_reset;
    endtask

    task automatic go_to(input int c);
        while (cycle < c) step();
    endtask

    // Leaves the bench in cycle 0 (first cycle with reset low)
    task automatic do_reset(input logic lock);
        reset    = 1'b1;
        cfg_req  = 1'b0;
        pll_lock = lock;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        cycle    = 0;
        acks     = 0;
        pr_rises = 0;
        lcd_low  = 0;
        prev_pr  = pll_reset;
    endtask

    task automatic set_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
        cfg_idsel  = id;
        cfg_fbdsel = fb;
        cfg_odsel  = od;
        cfg_req    = 1'b1;
    endtask

    initial begin
        int acks_before;
        reset      = 1'b1;
        cfg_req    = 1'b0;
        cfg_idsel  = '0;
        cfg_fbdsel = '0;
        cfg_odsel  = '0;
        pll_lock   = 1'b0;

        // restart, lock, cycle, pll_reset, lcd_reset, ready, fault, ack, retry
        vecs[0]  = '{1'b1, 1'b1, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 3,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 4,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 12,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 13,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 20,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 1'b0, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 1'b0, 4,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b0, 1'b0, 35,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b0, 1'b0, 36,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[10] = '{1'b0, 1'b0, 39,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[11] = '{1'b0, 1'b0, 40,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[12] = '{1'b0, 1'b0, 71,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[13] = '{1'b0, 1'b0, 72,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[14] = '{1'b0, 1'b0, 76,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[15] = '{1'b0, 1'b0, 107, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[16] = '{1'b0, 1'b0, 108, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[17] = '{1'b0, 1'b0, 150, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};

        // Table: clean start and permanent no-lock
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].restart) begin
                do_reset(vecs[i].lock);
                chk_sel($sformatf("vec%0d.init", i), c_INIT_SEL);
            end
            go_to(vecs[i].cyc);
            chk_outs($sformatf("vec%0d", i), vecs[i].pr, vecs[i].lr, vecs[i].rdy,
                     vecs[i].flt, vecs[i].ack, vecs[i].retry);
        end
        chk("nolock.lcd_never_released", 32'(lcd_low), 32'd0);

        // Lock glitch in STABLE: lock_s low at cycle 10, full recount, RUN at 20
        do_reset(1'b1);
        go_to(8);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        go_to(13);
        chk("glitch.ready_c13", 32'(ready), 32'd0);
        go_to(19);
        chk("glitch.ready_c19", 32'(ready), 32'd0);
        go_to(20);
        chk_outs("glitch.c20", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Reconfigure in RUN, then a request raised in STABLE waits for RUN
        do_reset(1'b1);
        go_to(20);
        set_cfg(6'd3, 6'd10, 6'd8);
        step();
        chk_outs("reconf.c21", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk_sel("reconf.c21", {6'd3, 6'd10, 6'd8});
        cfg_req = 1'b0;
        step();
        chk("reconf.ack_one_cycle", 32'(cfg_ack), 32'd0);
        go_to(28);
        set_cfg(6'd5, 6'd6, 6'd7);
        acks_before = acks;
        go_to(33);
        chk("reconf.ready_c33", 32'(ready), 32'd0);
        go_to(34);
        chk("reconf.ready_c34", 32'(ready), 32'd1);
        chk("pending.no_ack_before_run", 32'(acks - acks_before), 32'd0);
        chk_sel("pending.sel_held", {6'd3, 6'd10, 6'd8});
        step();
        chk_outs("pending.c35", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk_sel("pending.c35", {6'd5, 6'd6, 6'd7});
        cfg_req = 1'b0;
        go_to(48);
        chk("pending.ready_c48", 32'(ready), 32'd1);

        // Recovery from FAULT
        do_reset(1'b0);
        go_to(108);
        chk("recover.fault_c108", 32'(fault), 32'd1);
        go_to(110);
        set_cfg(6'd9, 6'd9, 6'd9);
        pll_lock = 1'b1;
        step();
        chk_outs("recover.c111", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk_sel("recover.c111", {6'd9, 6'd9, 6'd9});
        cfg_req = 1'b0;
        go_to(123);
        chk("recover.ready_c123", 32'(ready), 32'd0);
        go_to(124);
        chk_outs("recover.c124", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Lock loss in RUN: ready falls 3 cycles after pll_lock
        do_reset(1'b1);
        go_to(18);
        pll_lock = 1'b0;
        go_to(20);
        chk("lockloss.ready_c20", 32'(ready), 32'd1);
        step();
        chk_outs("lockloss.c21", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Lock loss coincident with cfg_req in RUN
        do_reset(1'b1);
        go_to(18);
        pll_lock = 1'b0;
        go_to(20);
        set_cfg(6'd3, 6'd10, 6'd8);
        acks     = 0;
        pr_rises = 0;
        step();
        chk_outs("coinc.c21", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk_sel("coinc.c21", {6'd3, 6'd10, 6'd8});
        cfg_req  = 1'b0;
        pll_lock = 1'b1;
        go_to(40);
        chk("coinc.ack_count", 32'(acks), 32'd1);
        chk("coinc.reset_entries", 32'(pr_rises), 32'd1);
        chk("coinc.ready_c40", 32'(ready), 32'd1);

        // Reset asserted in WAIT_LOCK with a pending request and changed selects
        do_reset(1'b1);
        go_to(20);
        set_cfg(6'd3, 6'd10, 6'd8);
        step();
        cfg_req  = 1'b0;
        pll_lock = 1'b0;
        go_to(27);
        set_cfg(6'd5, 6'd6, 6'd7);
        go_to(29);
        chk("midreset.wait_lock_c29", 32'(pll_reset), 32'd0);
        chk("midreset.retry_c29", 32'(retry_cnt), 32'd0);
        reset = 1'b1;
        acks  = 0;
        step();
        chk_outs("midreset.c30", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_sel("midreset.c30", c_INIT_SEL);
        step();
        chk("midreset.no_ack", 32'(acks), 32'd0);
        reset   = 1'b0;
        cfg_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_pll_ctrl.md
# lcd_pll_ctrl

Sequencing and reconfiguration controller for the LCD pixel-clock rPLL. It runs on the free-running 25 MHz reference that also feeds the PLL's `clkin`. It drives the PLL's `RESET` and dynamic divider selects (`IDSEL`/`FBDSEL`/`ODSEL`), supervises `lock`, and holds the LCD pixel domain in reset until lock has been stable. It retries on lock timeout, and accepts runtime divider changes for LCD mode switches through a req/ack handshake.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥2).
- `LOCK_WAIT`, 2500: consecutive synced-lock cycles required before release (100 µs at 25 MHz).
- `LOCK_TIMEOUT`, 25000: cycles allowed in WAIT_LOCK per attempt.
- `MAX_RETRY`, 3: re-attempts after the first before FAULT (0..15).
- `INIT_IDSEL` / `INIT_FBDSEL` / `INIT_ODSEL`, 6'd0: divider selects loaded on reset, passed through in the PLL's native encoding.

Ports:
- `clk`  in  1  reference clock, same net as PLL `clkin`.
- `reset`  in  1  synchronous, active-high.
- `cfg_req`  in  1  request new divider settings; held high until `cfg_ack`.
- `cfg_idsel` / `cfg_fbdsel` / `cfg_odsel`  in  6 each  requested selects; stable while `cfg_req` is high.
- `cfg_ack`  out  1  one-cycle pulse; request accepted and data latched.
- `pll_lock`  in  1  PLL `lock`, asynchronous; 2-flop synchronised internally (`lock_s`).
- `pll_reset`  out  1  to PLL `RESET`.
- `pll_idsel` / `pll_fbdsel` / `pll_odsel`  out  6 each  to PLL dynamic selects.
- `lcd_reset`  out  1  active-high reset for the pixel-clock domain.
- `ready`  out  1  PLL locked and stable, LCD domain released.
- `fault`  out  1  retries exhausted; sticky.
- `retry_cnt`  out  4  attempts used in the current sequence.

## Operation
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT. All outputs are registered and decoded from the registered state.
- Reset values:
  - state RESET_PLL; `pll_reset`=1, `lcd_reset`=1.
  - `ready`=0, `fault`=0, `cfg_ack`=0, `retry_cnt`=0.
  - selects = INIT_*; sync flops and all counters = 0.
- RESET_PLL: `pll_reset`=1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK: `pll_reset`=0.
  - `lock_s`=1: go to STABLE with the stable counter cleared.
  - Otherwise, on timer = LOCK_TIMEOUT−1: if `retry_cnt` < MAX_RETRY, increment it and go to RESET_PLL; else go to FAULT.
- STABLE: counts cycles with `lock_s`=1.
  - `lock_s`=0: go to WAIT_LOCK with the timer cleared; `retry_cnt` unchanged.
  - Count = LOCK_WAIT−1: go to RUN and clear `retry_cnt`.
- RUN: `lcd_reset`=0, `ready`=1.
  - `lock_s`=0: go to RESET_PLL; `lcd_reset`=1 and `ready`=0 from the next cycle.
- FAULT: `pll_reset`=1, `lcd_reset`=1, `fault`=1. The state persists until `reset` or an accepted `cfg_req`.
- Handshake:
  - `cfg_req` is sampled only in RUN and FAULT. In other states it stays pending, with no ack.
  - On acceptance: `cfg_ack`=1 for one cycle; `cfg_*` latched into `pll_*sel`; `retry_cnt`=0; `fault` cleared; go to RESET_PLL.
  - Selects never change while `pll_reset`=0.
- Simultaneous lock loss and `cfg_req` in RUN: the request is accepted (ack plus new selects), with a single pass into RESET_PLL.
- `reset` mid-sequence returns every output to its reset value on the next edge, including a pending handshake; no ack is issued.

## Timing
- Cycle 0 is the first cycle with `reset` low.
- `lock_s` lags `pll_lock` by 2 cycles.
- With `pll_lock` constantly high:
  - RESET_PLL spans cycles 0..PLL_RST_CYCLES−1.
  - WAIT_LOCK lasts 1 cycle.
  - STABLE lasts LOCK_WAIT cycles.
  - `ready` rises and `lcd_reset` falls at cycle PLL_RST_CYCLES+1+LOCK_WAIT.
- Each failed attempt costs PLL_RST_CYCLES+LOCK_TIMEOUT cycles. `fault` rises after (MAX_RETRY+1) attempts.
- `cfg_ack` occurs in the cycle after `cfg_req` is first seen in RUN/FAULT. New selects and `pll_reset`=1 are present in that same cycle.
- Lock loss in RUN: `ready` falls 3 cycles after `pll_lock` falls (2 cycles of sync plus the registered state).

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_WAIT=8, LOCK_TIMEOUT=32, MAX_RETRY=2.
- Clean start, `pll_lock`=1: `pll_reset` high for cycles 0..3; `ready`=1 and `lcd_reset`=0 at cycle 13; `retry_cnt`=0.
- `pll_lock`=0 permanently: three `pll_reset` pulses of 4 cycles each; `retry_cnt` steps 0→1→2; `fault`=1 at cycle 108; `lcd_reset` never falls.
- Lock glitch in STABLE (lock low for 1 cycle after 5 stable cycles): return to WAIT_LOCK, then a full 8-cycle STABLE recount; `ready` delayed accordingly; `retry_cnt` stays 0.
- Reconfigure in RUN, `cfg_req` with idsel=3, fbdsel=10, odsel=8:
  - `cfg_ack` pulses once; `pll_*sel` = 3/10/8 while `pll_reset`=1; `ready` drops.
  - `ready` returns 13 cycles after the ack.
  - A `cfg_req` raised during STABLE is not acked until RUN.
- Recovery from FAULT: `cfg_req` is acked, `fault` clears the next cycle, and the sequence restarts; with lock high, `ready`=1 13 cycles later.
- Lock loss coincident with `cfg_req` in RUN: exactly one ack, one RESET_PLL entry, and the new selects applied. `reset` asserted in WAIT_LOCK restores all outputs to their reset values on the next edge.
